interval_scheduler: RTL and testbench

Shares one interval counter between NREQ requesters. Each requester asks for a delay of D prescaler ticks. A round-robin arbiter grants the counter to one requester at a time. The FSM clears and runs the counter for the granted requester and pulses that requester's done bit when the interval expires. It sits between the tick prescaler (source of tick_en) and client FSMs that need timed waits, such as debouncers and LED sequencers.

---
 rtl/sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/interval_scheduler.sv | 127 ++++++++++++
 tb/tb_interval_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types for the interval scheduler: FSM state encoding and
// the upper bound on the number of requesters.
package sched_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the pointer
// and wraps, so the last-served requester has lowest priority.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] pointer,
    output logic [NREQ-1:0]         gnt_onehot,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = IW'((int'(pointer) + off) % NREQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interval_scheduler.sv
// Shares one interval counter between NREQ requesters: round-robin grant,
// count prescaler ticks up to the owner's delay, then pulse its done bit.
module interval_scheduler
    import sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] delay,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      count
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    dly_q, dly_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [W-1:0]    dly_sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .pointer    (ptr_q),
        .gnt_onehot (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        dly_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) dly_sel = delay[i*W +: W];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        count_d = count_q;
        dly_d   = dly_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (arb_any) begin
                    dly_d   = dly_sel;
                    count_d = '0;
                    grant_d = arb_gnt;
                    owner_d = arb_idx;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Owner dropped its request: release silently, skip it next time.
                if ((req & grant_q) == '0) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = owner_q;
                    state_d = S_IDLE;
                end else if (count_q == dly_q) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else if (tick_en) begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: all state is reset, including the latched delay; these are
        // plain registers, not a memory array, so the cost is negligible.
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            dly_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            dly_q   <= dly_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: tb/tb_interval_scheduler.sv
// Directed bench for interval_scheduler (NREQ=4, W=8); inputs change and
// outputs are sampled on the falling edge.
module tb_interval_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick_en;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] delay;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      count;

    int n_checks = 0;
    int n_errors = 0;

    interval_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_en (tick_en),
        .req     (req),
        .delay   (delay),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_delay(input int i, input logic [W-1:0] v);
        delay[i*W +: W] = v;
    endtask

    logic [NREQ-1:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        reset   = 1'b1;
        tick_en = 1'b0;
        req     = '0;
        delay   = '0;
        @(negedge clk);
        step();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        reset = 1'b0;
        step();

        // Single request, delay 5, tick every cycle
        set_delay(2, 5);
        tick_en = 1'b1;
        req     = 4'b0100;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) begin
                check("t1_grant", grant, 4'b0100);
                check("t1_busy", busy, 1);
            end
            if (e <= 6) check("t1_count", count, e - 1);
            check("t1_done", done, (e == 7) ? 4'b0100 : 4'b0000);
            if (e == 7) begin
                check("t1_count_final", count, 5);
                check("t1_grant_held", grant, 4'b0100);
                req = '0;
            end
            if (e == 8) begin
                check("t1_grant_off", grant, 0);
                check("t1_busy_off", busy, 0);
            end
        end

        // Prescaled ticks: tick on every 4th edge, delay 3
        set_delay(1, 3);
        req = 4'b0010;
        for (int e = 1; e <= 14; e++) begin
            tick_en = (e % 4 == 0);
            step();
            if (e <= 13)
                check("t2_count", count, (e < 4) ? 0 : (e < 8) ? 1 : (e < 12) ? 2 : 3);
            check("t2_done", done, (e == 13) ? 4'b0010 : 4'b0000);
            if (e == 13) req = '0;
            if (e == 14) check("t2_grant_off", grant, 0);
        end

        // Delay 0 with tick_en low
        tick_en = 1'b0;
        set_delay(0, 0);
        req = 4'b0001;
        step();
        check("t3_grant", grant, 4'b0001);
        check("t3_done_early", done, 0);
        step();
        check("t3_done", done, 4'b0001);
        req = '0;
        step();
        check("t3_grant_off", grant, 0);
        check("t3_done_off", done, 0);

        // Delay 255: no wrap, count holds through DONE and into IDLE
        tick_en = 1'b1;
        set_delay(3, 255);
        req = 4'b1000;
        for (int e = 1; e <= 258; e++) begin
            step();
            if (e == 200) check("t4_count_mid", count, 199);
            if (e == 256) begin
                check("t4_count_max", count, 255);
                check("t4_done_early", done, 0);
            end
            if (e == 257) begin
                check("t4_done", done, 4'b1000);
                check("t4_count_done", count, 255);
                req = '0;
            end
            if (e == 258) begin
                check("t4_count_hold", count, 255);
                check("t4_grant_off", grant, 0);
            end
        end

        // Fairness: all requesting, all delay 1
        for (int i = 0; i < NREQ; i++) set_delay(i, 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int  pulses;
            int  wait_n;
            wait_n = 0;
            while (grant == '0 && wait_n < 8) begin
                step();
                wait_n++;
            end
            check("t5_grant_seen", (grant != '0), 1);
            check("t5_grant_order", grant, fair_exp[i]);
            pulses = 0;
            wait_n = 0;
            while (grant != '0 && wait_n < 8) begin
                step();
                wait_n++;
                if (done != '0) begin
                    pulses++;
                    check("t5_done_who", done, fair_exp[i]);
                end
            end
            check("t5_done_pulses", pulses, 1);
        end
        req = '0;
        step();

        // Abort: requester 1 drops at count 2, requester 2 pending
        set_delay(1, 10);
        set_delay(2, 2);
        req = 4'b0110;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("t6_done", done, 0);
            if (e == 1) check("t6_grant", grant, 4'b0010);
            if (e == 3) begin
                check("t6_count", count, 2);
                req = 4'b0100;
            end
            if (e == 4) begin
                check("t6_grant_off", grant, 0);
                check("t6_busy_off", busy, 0);
            end
            if (e == 5) check("t6_next_grant", grant, 4'b0100);
        end
        req = '0;
        step();
        step();
        check("t6_idle", busy, 0);

        // Reset mid-interval, then all requesters active
        set_delay(3, 10);
        req = 4'b1000;
        for (int e = 1; e <= 5; e++) step();
        check("t7_grant", grant, 4'b1000);
        check("t7_count", count, 4);
        reset = 1'b1;
        req   = 4'b1111;
        step();
        check("t7_rst_grant", grant, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_count", count, 0);
        check("t7_rst_done", done, 0);
        reset = 1'b0;
        step();
        check("t7_first_grant", grant, 4'b0001);
        check("t7_first_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
